// File: rtl/rob_wb_arbiter_if.sv
// Completion-request and ROB-writeback bundle for the writeback arbiter.
// The functional units plus the ROB sit on the master side; the arbiter
// takes the slave modport.
interface rob_wb_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    localparam int PTR_W = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   wb0_valid;
    logic [TAG_W-1:0]       wb0_tag;
    logic [DATA_W-1:0]      wb0_data;
    logic                   wb1_valid;
    logic [TAG_W-1:0]       wb1_tag;
    logic [DATA_W-1:0]      wb1_data;
    logic [PTR_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]       stall_cnt;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready,
        input  wb0_valid, wb0_tag, wb0_data,
        input  wb1_valid, wb1_tag, wb1_data,
        input  rr_ptr, stall_cnt
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready,
        output wb0_valid, wb0_tag, wb0_data,
        output wb1_valid, wb1_tag, wb1_data,
        output rr_ptr, stall_cnt
    );
endinterface

// File: rtl/rob_wb_arbiter.sv
// Round-robin arbiter sharing the two ROB writeback ports among NREQ
// functional-unit completion requesters. Up to two grants per cycle are
// made combinationally and registered onto wb0/wb1 one cycle later.
module rob_wb_arbiter #(
    parameter int NREQ   = 4,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rob_wb_arbiter_if.slave      bus
);
    localparam int                 PTR_W  = $clog2(NREQ);
    localparam logic [PTR_W-1:0]   LAST   = PTR_W'(NREQ - 1);
    localparam logic [PTR_W:0]     NREQ_V = (PTR_W + 1)'(NREQ);

    // Pointer after index p, wrapping explicitly so non-power-of-2 NREQ works.
    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Reduce rr_ptr + offset (always < 2*NREQ) back into 0..NREQ-1.
    function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W:0] s);
        return (s >= NREQ_V) ? PTR_W'(s - NREQ_V) : s[PTR_W-1:0];
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [TAG_W-1:0]  w_tag_a  [NREQ];
    logic [DATA_W-1:0] w_data_a [NREQ];
    logic              w_g0;
    logic              w_g1;
    logic [PTR_W-1:0]  w_s0;
    logic [PTR_W-1:0]  w_s1;
    logic [PTR_W-1:0]  w_idx;
    logic [NREQ-1:0]   w_ready;
    logic              w_stall;

    logic              r_wb0_valid;
    logic [TAG_W-1:0]  r_wb0_tag;
    logic [DATA_W-1:0] r_wb0_data;
    logic              r_wb1_valid;
    logic [TAG_W-1:0]  r_wb1_tag;
    logic [DATA_W-1:0] r_wb1_data;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]  r_stall_cnt;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_tag_a[gi]  = bus.req_tag[gi*TAG_W +: TAG_W];
        assign w_data_a[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    // Scan from rr_ptr upward: first valid requester -> slot 0, second -> slot 1.
    always_comb begin
        w_g0  = 1'b0;
        w_g1  = 1'b0;
        w_s0  = '0;
        w_s1  = '0;
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = f_wrap({1'b0, r_rr_ptr} + (PTR_W + 1)'(k));
            if (bus.req_valid[w_idx]) begin
                if (!w_g0) begin
                    w_g0 = 1'b1;
                    w_s0 = w_idx;
                end else if (!w_g1) begin
                    w_g1 = 1'b1;
                    w_s1 = w_idx;
                end
            end
        end
    end

    // Ready goes only to the granted requesters and is suppressed during reset.
    always_comb begin
        w_ready = '0;
        if (!rst) begin
            if (w_g0) w_ready[w_s0] = 1'b1;
            if (w_g1) w_ready[w_s1] = 1'b1;
        end
    end

    assign w_stall = ($countones(bus.req_valid) > 2);

    // Register granted slots onto the writeback ports and advance fairness state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb0_valid <= 1'b0;
            r_wb0_tag   <= '0;
            r_wb0_data  <= '0;
            r_wb1_valid <= 1'b0;
            r_wb1_tag   <= '0;
            r_wb1_data  <= '0;
            r_rr_ptr    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_wb0_valid <= w_g0;
            r_wb1_valid <= w_g1;
            if (w_g0) begin
                r_wb0_tag  <= w_tag_a[w_s0];
                r_wb0_data <= w_data_a[w_s0];
            end
            if (w_g1) begin
                r_wb1_tag  <= w_tag_a[w_s1];
                r_wb1_data <= w_data_a[w_s1];
            end
            // Priority moves just past the last requester served this cycle.
            if (w_g1) begin
                r_rr_ptr <= f_next_ptr(w_s1);
            end else if (w_g0) begin
                r_rr_ptr <= f_next_ptr(w_s0);
            end
            if (w_stall) begin
                r_stall_cnt <= f_sat_inc(r_stall_cnt);
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wb0_valid = r_wb0_valid;
    assign bus.wb0_tag   = r_wb0_tag;
    assign bus.wb0_data  = r_wb0_data;
    assign bus.wb1_valid = r_wb1_valid;
    assign bus.wb1_tag   = r_wb1_tag;
    assign bus.wb1_data  = r_wb1_data;
    assign bus.rr_ptr    = r_rr_ptr;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Testbench for rob_wb_arbiter: directed scenarios plus a randomized run
// against a behavioural round-robin model.
module tb_rob_wb_arbiter;
    localparam int NREQ    = 4;
    localparam int TAG_W   = 3;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;
    localparam int PTR_W   = 2;
    localparam int SAT_CYC = (1 << CNT_W) + 3;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    // Model state
    int                m_ptr;
    int                m_stall;
    logic              m_wb0v, m_wb1v;
    logic [TAG_W-1:0]  m_wb0t, m_wb1t;
    logic [DATA_W-1:0] m_wb0d, m_wb1d;

    rob_wb_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bif ();

    rob_wb_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        bif.req_tag[i*TAG_W +: TAG_W]    = t;
        bif.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.req_valid = '0;
        tick();
        rst = 1'b0;
        m_ptr = 0; m_stall = 0;
        m_wb0v = 0; m_wb1v = 0; m_wb0t = '0; m_wb1t = '0; m_wb0d = '0; m_wb1d = '0;
    endtask

    // Round-robin rule: walk indices ptr, ptr+1, ... mod NREQ; first two valid win.
    function automatic void model_grant(input logic [NREQ-1:0] v, input int ptr,
                                        output int s0, output int s1);
        s0 = -1;
        s1 = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (v[i]) begin
                if (s0 < 0) s0 = i;
                else if (s1 < 0) s1 = i;
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bif.req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, TAG_W'(i), 32'h1000 + DATA_W'(i));
        #1;
        vectors++;
        if (bif.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bif.req_ready); end
        tick();
        tick();
        vectors++;
        if (bif.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready2: got %b expected 0000", bif.req_ready); end
        vectors++;
        if (bif.wb0_valid !== 1'b0 || bif.wb1_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b%b expected 00", bif.wb0_valid, bif.wb1_valid);
        end
        vectors++;
        if (bif.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", bif.rr_ptr); end
        vectors++;
        if (bif.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", bif.stall_cnt); end
        vectors++;
        if (bif.wb0_tag !== 3'd0 || bif.wb0_data !== 32'd0 || bif.wb1_tag !== 3'd0 || bif.wb1_data !== 32'd0) begin
            errors++; $display("FAIL reset_data: got %h/%h %h/%h expected zeros",
                               bif.wb0_tag, bif.wb0_data, bif.wb1_tag, bif.wb1_data);
        end
        rst = 1'b0;
        bif.req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        bif.req_valid = 4'b0100;
        set_req(2, 3'd5, 32'hDEAD_BEEF);
        #1;
        vectors++;
        if (bif.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", bif.req_ready); end
        tick();
        bif.req_valid = '0;
        vectors++;
        if (bif.wb0_valid !== 1'b1 || bif.wb1_valid !== 1'b0) begin
            errors++; $display("FAIL single_valid: got %b%b expected 10", bif.wb0_valid, bif.wb1_valid);
        end
        vectors++;
        if (bif.wb0_tag !== 3'd5 || bif.wb0_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_data: got %h/%h expected 5/deadbeef", bif.wb0_tag, bif.wb0_data);
        end
        vectors++;
        if (bif.rr_ptr !== 2'd3) begin errors++; $display("FAIL single_ptr: got %0d expected 3", bif.rr_ptr); end
    endtask

    task automatic test_two();
        // From rr_ptr=3, a lone grant to requester 3 wraps the pointer to 0.
        bif.req_valid = 4'b1000;
        set_req(3, 3'd2, 32'h0);
        tick();
        vectors++;
        if (bif.rr_ptr !== 2'd0) begin errors++; $display("FAIL two_preptr: got %0d expected 0", bif.rr_ptr); end
        bif.req_valid = 4'b1001;
        set_req(0, 3'd1, 32'hAAAA_0001);
        set_req(3, 3'd6, 32'hBBBB_0006);
        #1;
        vectors++;
        if (bif.req_ready !== 4'b1001) begin errors++; $display("FAIL two_ready: got %b expected 1001", bif.req_ready); end
        tick();
        bif.req_valid = '0;
        vectors++;
        if (bif.wb0_valid !== 1'b1 || bif.wb0_tag !== 3'd1 || bif.wb0_data !== 32'hAAAA_0001) begin
            errors++; $display("FAIL two_wb0: got %b/%h/%h expected 1/1/aaaa0001", bif.wb0_valid, bif.wb0_tag, bif.wb0_data);
        end
        vectors++;
        if (bif.wb1_valid !== 1'b1 || bif.wb1_tag !== 3'd6 || bif.wb1_data !== 32'hBBBB_0006) begin
            errors++; $display("FAIL two_wb1: got %b/%h/%h expected 1/6/bbbb0006", bif.wb1_valid, bif.wb1_tag, bif.wb1_data);
        end
        vectors++;
        if (bif.rr_ptr !== 2'd0) begin errors++; $display("FAIL two_ptr: got %0d expected 0", bif.rr_ptr); end
    endtask

    task automatic test_all4();
        logic [NREQ-1:0] exp_rdy;
        logic [PTR_W-1:0] exp_ptr;
        logic [TAG_W-1:0] exp_t0, exp_t1;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, TAG_W'(i + 2), 32'h5000 + DATA_W'(i));
        bif.req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            exp_t0  = (c % 2 == 0) ? 3'd2 : 3'd4;
            exp_t1  = (c % 2 == 0) ? 3'd3 : 3'd5;
            exp_ptr = (c % 2 == 0) ? 2'd2 : 2'd0;
            #1;
            vectors++;
            if (bif.req_ready !== exp_rdy) begin errors++; $display("FAIL all4_ready[%0d]: got %b expected %b", c, bif.req_ready, exp_rdy); end
            tick();
            vectors++;
            if (bif.wb0_tag !== exp_t0 || bif.wb1_tag !== exp_t1 || !bif.wb0_valid || !bif.wb1_valid) begin
                errors++; $display("FAIL all4_pair[%0d]: got %0d,%0d expected %0d,%0d", c, bif.wb0_tag, bif.wb1_tag, exp_t0, exp_t1);
            end
            vectors++;
            if (bif.rr_ptr !== exp_ptr) begin errors++; $display("FAIL all4_ptr[%0d]: got %0d expected %0d", c, bif.rr_ptr, exp_ptr); end
        end
        vectors++;
        if (bif.stall_cnt !== 16'd4) begin errors++; $display("FAIL all4_stall: got %0d expected 4", bif.stall_cnt); end
        bif.req_valid = '0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0]   pv;
        logic [TAG_W-1:0]  pt [NREQ];
        logic [DATA_W-1:0] pd [NREQ];
        logic [NREQ-1:0]   exp_rdy;
        int s0, s1, ones;
        do_reset();
        pv = '0;
        for (int i = 0; i < NREQ; i++) begin pt[i] = '0; pd[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            // Idle requesters may present a new result; pending ones hold.
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && ($urandom_range(0, 99) < 55)) begin
                    pv[i] = 1'b1;
                    pt[i] = TAG_W'($urandom);
                    pd[i] = $urandom;
                end
            end
            bif.req_valid = pv;
            for (int i = 0; i < NREQ; i++) set_req(i, pt[i], pd[i]);
            #1;
            model_grant(pv, m_ptr, s0, s1);
            exp_rdy = '0;
            if (s0 >= 0) exp_rdy[s0] = 1'b1;
            if (s1 >= 0) exp_rdy[s1] = 1'b1;
            vectors++;
            if (bif.req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, bif.req_ready, exp_rdy); end
            tick();
            ones = 0;
            for (int i = 0; i < NREQ; i++) ones += int'(pv[i]);
            if (ones > 2 && m_stall < 65535) m_stall++;
            m_wb0v = (s0 >= 0);
            m_wb1v = (s1 >= 0);
            if (s0 >= 0) begin m_wb0t = pt[s0]; m_wb0d = pd[s0]; pv[s0] = 1'b0; end
            if (s1 >= 0) begin m_wb1t = pt[s1]; m_wb1d = pd[s1]; pv[s1] = 1'b0; end
            if (s1 >= 0) m_ptr = (s1 + 1) % NREQ;
            else if (s0 >= 0) m_ptr = (s0 + 1) % NREQ;
            vectors++;
            if (bif.wb0_valid !== m_wb0v || bif.wb0_tag !== m_wb0t || bif.wb0_data !== m_wb0d) begin
                errors++; $display("FAIL rand_wb0[%0d]: got %b/%h/%h expected %b/%h/%h", c,
                                   bif.wb0_valid, bif.wb0_tag, bif.wb0_data, m_wb0v, m_wb0t, m_wb0d);
            end
            vectors++;
            if (bif.wb1_valid !== m_wb1v || bif.wb1_tag !== m_wb1t || bif.wb1_data !== m_wb1d) begin
                errors++; $display("FAIL rand_wb1[%0d]: got %b/%h/%h expected %b/%h/%h", c,
                                   bif.wb1_valid, bif.wb1_tag, bif.wb1_data, m_wb1v, m_wb1t, m_wb1d);
            end
            vectors++;
            if (bif.rr_ptr !== PTR_W'(m_ptr) || bif.stall_cnt !== CNT_W'(m_stall)) begin
                errors++; $display("FAIL rand_state[%0d]: got ptr %0d stall %0d expected ptr %0d stall %0d", c,
                                   bif.rr_ptr, bif.stall_cnt, m_ptr, m_stall);
            end
        end
        bif.req_valid = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        bif.req_valid = 4'b0111;
        for (int n = 1; n <= SAT_CYC; n++) begin
            tick();
            if (n == 65534) begin
                vectors++;
                if (bif.stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", bif.stall_cnt); end
            end
            if (n == 65535) begin
                vectors++;
                if (bif.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h expected ffff", bif.stall_cnt); end
            end
        end
        vectors++;
        if (bif.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", bif.stall_cnt); end
        bif.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 3'd1, 32'h1111_1111);
        set_req(1, 3'd2, 32'h2222_2222);
        set_req(2, 3'd3, 32'h3333_3333);
        bif.req_valid = 4'b0111;
        tick();
        vectors++;
        if (bif.rr_ptr !== 2'd2) begin errors++; $display("FAIL mid_preptr: got %0d expected 2", bif.rr_ptr); end
        rst = 1'b1;
        #1;
        vectors++;
        if (bif.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_rst: got %b expected 0000", bif.req_ready); end
        tick();
        vectors++;
        if (bif.wb0_valid !== 1'b0 || bif.wb1_valid !== 1'b0 || bif.wb0_tag !== 3'd0 || bif.wb0_data !== 32'd0) begin
            errors++; $display("FAIL mid_out: got %b%b %h/%h expected 00 0/0", bif.wb0_valid, bif.wb1_valid, bif.wb0_tag, bif.wb0_data);
        end
        vectors++;
        if (bif.rr_ptr !== 2'd0 || bif.stall_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_state: got ptr %0d stall %0d expected 0 0", bif.rr_ptr, bif.stall_cnt);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bif.req_ready !== 4'b0011) begin errors++; $display("FAIL mid_ready_after: got %b expected 0011", bif.req_ready); end
        tick();
        vectors++;
        if (bif.wb0_tag !== 3'd1 || bif.wb1_tag !== 3'd2 || !bif.wb0_valid || !bif.wb1_valid || bif.rr_ptr !== 2'd2) begin
            errors++; $display("FAIL mid_regrant: got %0d,%0d ptr %0d expected 1,2 ptr 2", bif.wb0_tag, bif.wb1_tag, bif.rr_ptr);
        end
        bif.req_valid = '0;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        bif.req_valid = '0;
        bif.req_tag   = '0;
        bif.req_data  = '0;
        test_reset();
        test_single();
        test_two();
        test_all4();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/rob_wb_arbiter.md
Name: rob_wb_arbiter

Overview:
- Shares the two ROB writeback ports (wb0/wb1) among NREQ functional-unit completion requesters.
- Each cycle it grants up to two pending completions using round-robin priority and drives them onto registered wb0/wb1 outputs one cycle later.
- Sits between the execute-stage functional units and the ROB. It tracks arbitration fairness and counts stall cycles.

Parameters:
NREQ, 4, number of completion requesters (2..8)
TAG_W, 3, ROB tag width
DATA_W, 32, result data width
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  requester i has a completed result
req_tag  input  NREQ*TAG_W  ROB tag of requester i, slice [i*TAG_W +: TAG_W]
req_data  input  NREQ*DATA_W  result of requester i, slice [i*DATA_W +: DATA_W]
req_ready  output  NREQ  combinational grant; transfer when req_valid[i] & req_ready[i]
wb0_valid  output  1  registered ROB writeback port 0 valid
wb0_tag  output  TAG_W  port 0 tag
wb0_data  output  DATA_W  port 0 data
wb1_valid  output  1  registered ROB writeback port 1 valid
wb1_tag  output  TAG_W  port 1 tag
wb1_data  output  DATA_W  port 1 data
rr_ptr  output  clog2(NREQ)  current highest-priority requester index (debug)
stall_cnt  output  CNT_W  saturating count of cycles in which some valid request was not granted

Behaviour:
- Reset (rst=1 at a clock edge): wb0/wb1 valid, tag and data all go to 0; rr_ptr=0; stall_cnt=0. req_ready is 0 while rst is high.
- Reset mid-operation: any grants in that cycle are discarded and no transfer occurs. Requesters keep valid asserted and are re-arbitrated after reset.
- Priority order: scan i = rr_ptr, rr_ptr+1, ..., wrapping mod NREQ.
  - First valid requester in scan order → slot 0.
  - Second valid requester in scan order → slot 1.
  - All other requests are not granted this cycle.
- req_ready[i] = 1 only for the requesters assigned to slot 0 or slot 1. It is purely combinational from req_valid and rr_ptr, and never asserted for an invalid requester.
- Handshake: a requester holds valid, tag and data stable until it sees ready. The transfer completes in the cycle where valid & ready are both 1. The requester may drop valid or present a new result the next cycle.
- Latency 1: slot 0 and slot 1 contents are registered into wb0_* and wb1_* at the same edge; ROB sees them the cycle after the grant.
  - One grant: it always goes to wb0; wb1_valid=0.
  - No grant: both valid outputs are 0. tag and data hold their previous values (don't-care when not valid).
- No backpressure from the ROB: the ROB accepts every wb cycle. The arbiter has no internal queue beyond the output register.
- rr_ptr update:
  - If ≥1 grant: rr_ptr ← (index of last granted requester + 1) mod NREQ. "Last granted" is slot 1 if used, else slot 0.
  - No grant: rr_ptr unchanged.
  - Wrap-around is explicit modulo NREQ, including non-power-of-2 NREQ.
- Fairness: a continuously valid requester is granted within ceil((NREQ-1)/2)+1 cycles.
- stall_cnt increments by 1 in every cycle where popcount(req_valid) > 2. It saturates at all-ones and does not wrap.
- Tag uniqueness across requesters is the issuer's responsibility; the arbiter does not check it. Simultaneous identical tags on wb0 and wb1 are therefore never produced by a correct system.

Test Plan:
- Reset: rst=1 for 2 cycles with all req_valid=1 → req_ready=0, wb0_valid=wb1_valid=0, rr_ptr=0, stall_cnt=0.
- Single requester: req_valid=4'b0100, tag 3'd5, data 32'hDEAD_BEEF → req_ready=4'b0100. Next cycle wb0_valid=1, wb0_tag=5, wb0_data=DEADBEEF, wb1_valid=0; rr_ptr=3.
- Two requesters: rr_ptr=0, req_valid=4'b1001 (tags 1 and 6) → req_ready=4'b1001. Next cycle wb0 tag 1, wb1 tag 6; rr_ptr=0 (wrap from index 3).
- All four held valid for 4 cycles from rr_ptr=0 → grant pairs {0,1}, {2,3}, {0,1}, {2,3}; rr_ptr sequence 2,0,2,0; stall_cnt=4.
- Saturation: force 2^CNT_W+3 cycles with 3 valid requests → stall_cnt stays at 16'hFFFF.
- Reset mid-stream: assert rst while 3 requests are pending → no transfer that cycle, outputs 0. After deassert, arbitration restarts at rr_ptr=0 and grants {0,1} first.
